program_loader: RTL and testbench

- Instruction-side counterpart of the 8-bit CPU datapath: consumes the core's PC and supplies the 8-bit instruction word.
- Holds a program RAM that the operator fills byte-by-byte from board switches and a push-button (LOAD mode).
- In RUN mode, serves mem[PC] combinationally and stops the core when PC runs past the loaded program.
- Sits between the board I/O and the datapath; its hold output gates the core.

---
 rtl/program_loader_pkg.sv | 14 +
 rtl/sync_edge.sv | 32 +++
 rtl/program_loader.sv | 148 ++++++++++++++
 tb/tb_program_loader.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared types and defaults for the program loader: FSM state encoding,
// default RAM address width and the instruction word used when the core must idle.
package program_loader_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  localparam int         ADDR_W_DEFAULT    = 8;
  localparam logic [7:0] NOP_INSTR_DEFAULT = 8'h00;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous board input, with an optional
// third flop that turns a rising edge into a single-cycle pulse.
module sync_edge #(
  parameter bit EDGE_EN = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic level_o,
  output logic pulse_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= EDGE_EN ? sync_q : 1'b0;
    end
  end

  assign level_o = sync_q;
  assign pulse_o = EDGE_EN ? (sync_q & ~prev_q) : 1'b0;

endmodule

// File: rtl/program_loader.sv
// Program RAM loaded byte-by-byte from switches, then served to the CPU by PC.
// Optional build macro PROGRAM_LOADER_CHECKSUM_EN adds a running byte checksum output.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int         ADDR_W    = ADDR_W_DEFAULT,
  parameter logic [7:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              run_sw,
  input  logic              wr_btn,
  input  logic [7:0]        data_sw,
  input  logic [7:0]        PC,
  output logic [7:0]        instruction,
  output logic              cpu_hold,
  output logic              halted,
  output logic              full,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  output logic [7:0]        checksum,
`endif
  output logic [ADDR_W:0]   load_count
);

  localparam int             DEPTH   = 2 ** ADDR_W;
  localparam int             CMP_W   = (ADDR_W + 1 > 8) ? ADDR_W + 1 : 8;
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W + 1)'(DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   load_count_q, load_count_d;
  logic [7:0]        mem [DEPTH];

  logic              run_sync;
  logic              wr_pulse;
  logic              run_pulse_unused;
  logic              wr_level_unused;
  logic              wr_en;
  logic              pc_past;
  logic [CMP_W-1:0]  pc_ext;
  logic [CMP_W-1:0]  cnt_ext;
  logic [ADDR_W-1:0] rd_addr;

  sync_edge #(.EDGE_EN(1'b0)) u_run_sync (
    .clk_i   (CLK),
    .rst_ni  (RESET),
    .async_i (run_sw),
    .level_o (run_sync),
    .pulse_o (run_pulse_unused)
  );

  sync_edge #(.EDGE_EN(1'b1)) u_wr_sync (
    .clk_i   (CLK),
    .rst_ni  (RESET),
    .async_i (wr_btn),
    .level_o (wr_level_unused),
    .pulse_o (wr_pulse)
  );

  assign full    = (load_count_q == CNT_MAX);
  assign pc_ext  = CMP_W'(PC);
  assign cnt_ext = CMP_W'(load_count_q);
  assign pc_past = (pc_ext >= cnt_ext);
  assign rd_addr = ADDR_W'(PC);

  // Leaving RUN/HALT always restarts the load from address 0; a mode change beats a strobe.
  always_comb begin
    state_d      = state_q;
    load_count_d = load_count_q;
    wr_en        = 1'b0;
    case (state_q)
      LOAD: begin
        if (run_sync && (load_count_q != '0)) begin
          state_d = RUN;
        end else if (wr_pulse && !full) begin
          wr_en        = 1'b1;
          load_count_d = load_count_q + CNT_ONE;
        end
      end
      RUN: begin
        if (!run_sync) begin
          state_d      = LOAD;
          load_count_d = '0;
        end else if (pc_past) begin
          state_d = HALT;
        end
      end
      HALT: begin
        if (!run_sync) begin
          state_d      = LOAD;
          load_count_d = '0;
        end
      end
      default: begin
        state_d      = LOAD;
        load_count_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q      <= LOAD;
      load_count_q <= '0;
    end else begin
      state_q      <= state_d;
      load_count_q <= load_count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[load_count_q[ADDR_W-1:0]] <= data_sw;
    end
  end

  assign instruction = ((state_q == RUN) && !pc_past) ? mem[rd_addr] : NOP_INSTR;
  assign cpu_hold    = (state_q != RUN);
  assign halted      = (state_q == HALT);
  assign load_count  = load_count_q;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0] checksum_q, checksum_d;
  logic       enter_load;

  assign enter_load = (state_q != LOAD) && (state_d == LOAD);

  always_comb begin
    checksum_d = checksum_q;
    if (enter_load) begin
      checksum_d = 8'h00;
    end else if (wr_en) begin
      checksum_d = checksum_q + data_sw;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      checksum_q <= 8'h00;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader: a full-size instance (A, ADDR_W=8)
// and a tiny instance (B, ADDR_W=2) share stimulus so overflow behaviour is visible.
module tb_program_loader;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       run_sw = 1'b0;
  logic       wr_btn = 1'b0;
  logic [7:0] data_sw = 8'h00;
  logic [7:0] PC = 8'h00;

  logic [7:0] instrA, instrB;
  logic       holdA, holdB, haltA, haltB, fullA, fullB;
  logic [8:0] cntOutA;
  logic [2:0] cntOutB;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0] sumOutA, sumOutB;
`endif

  int vectors = 0;
  int misses  = 0;

  logic [7:0] memA [256];
  logic [7:0] memB [4];
  int         cntA = 0;
  int         cntB = 0;
  logic [7:0] sumA = 8'h00;
  logic [7:0] expQ [$];

  always #5 CLK = ~CLK;

  program_loader #(.ADDR_W(8)) dutA (
    .CLK         (CLK),
    .RESET       (RESET),
    .run_sw      (run_sw),
    .wr_btn      (wr_btn),
    .data_sw     (data_sw),
    .PC          (PC),
    .instruction (instrA),
    .cpu_hold    (holdA),
    .halted      (haltA),
    .full        (fullA),
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    .checksum    (sumOutA),
`endif
    .load_count  (cntOutA)
  );

  program_loader #(.ADDR_W(2)) dutB (
    .CLK         (CLK),
    .RESET       (RESET),
    .run_sw      (run_sw),
    .wr_btn      (wr_btn),
    .data_sw     (data_sw),
    .PC          (PC),
    .instruction (instrB),
    .cpu_hold    (holdB),
    .halted      (haltB),
    .full        (fullB),
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    .checksum    (sumOutB),
`endif
    .load_count  (cntOutB)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      misses++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One button press; count must stay put for two edges and step on the third.
  task automatic applyStimulus(input logic [7:0] d);
    data_sw = d;
    wr_btn  = 1'b1;
    tick(2);
    checkOutput("cnt_latency_A", 16'(cntOutA), 16'(cntA));
    if (cntA < 256) begin
      memA[cntA] = d;
      cntA++;
      sumA = sumA + d;
    end
    if (cntB < 4) begin
      memB[cntB] = d;
      cntB++;
    end
    tick(1);
    checkOutput("cnt_A", 16'(cntOutA), 16'(cntA));
    checkOutput("cnt_B", 16'(cntOutB), 16'(cntB));
    checkOutput("full_B", 16'(fullB), 16'(cntB == 4));
    checkOutput("instr_load_A", 16'(instrA), 16'h00);
    wr_btn = 1'b0;
    tick(3);
  endtask

  task automatic readPc(input logic [7:0] pc);
    logic [7:0] expB;
    PC = pc;
    expQ.push_back((int'(pc) < cntA) ? memA[pc] : 8'h00);
    expB = (int'(pc) < cntB) ? memB[pc[1:0]] : 8'h00;
    #1;
    checkOutput("instr_A", 16'(instrA), 16'(expQ.pop_front()));
    checkOutput("instr_B", 16'(instrB), 16'(expB));
  endtask

  initial begin
    #1 RESET = 1'b0;
    #2;
    checkOutput("rst_hold", 16'(holdA), 16'h1);
    checkOutput("rst_halted", 16'(haltA), 16'h0);
    checkOutput("rst_full", 16'(fullA), 16'h0);
    checkOutput("rst_instr", 16'(instrA), 16'h00);
    checkOutput("rst_cnt", 16'(cntOutA), 16'h0);
    tick(2);
    RESET = 1'b1;
    tick(1);

    applyStimulus(8'h41);
    applyStimulus(8'h82);
    applyStimulus(8'hC3);
    checkOutput("full_A_3", 16'(fullA), 16'h0);

    run_sw = 1'b1;
    tick(2);
    checkOutput("hold_before_run", 16'(holdA), 16'h1);
    tick(1);
    checkOutput("hold_run", 16'(holdA), 16'h0);
    readPc(8'd0);
    readPc(8'd1);
    readPc(8'd2);
    readPc(8'd3);
    checkOutput("halted_same_cycle", 16'(haltA), 16'h0);
    tick(1);
    checkOutput("halted_A", 16'(haltA), 16'h1);
    checkOutput("halted_B", 16'(haltB), 16'h1);
    checkOutput("hold_halt", 16'(holdA), 16'h1);

    run_sw = 1'b0;
    tick(2);
    checkOutput("still_halted", 16'(haltA), 16'h1);
    tick(1);
    cntA = 0;
    cntB = 0;
    sumA = 8'h00;
    checkOutput("reload_halted", 16'(haltA), 16'h0);
    checkOutput("reload_cnt", 16'(cntOutA), 16'h0);
    checkOutput("reload_full", 16'(fullA), 16'h0);

    PC = 8'd0;
    run_sw = 1'b1;
    tick(4);
    checkOutput("empty_hold", 16'(holdA), 16'h1);
    checkOutput("empty_instr", 16'(instrA), 16'h00);
    run_sw = 1'b0;
    tick(3);

    applyStimulus(8'h11);
    applyStimulus(8'h22);
    applyStimulus(8'h33);
    applyStimulus(8'h44);
    applyStimulus(8'h55);
    checkOutput("full_B_sat", 16'(fullB), 16'h1);
    checkOutput("full_A_5", 16'(fullA), 16'h0);

    run_sw = 1'b1;
    tick(3);
    checkOutput("hold_run2_B", 16'(holdB), 16'h0);
    readPc(8'd0);
    readPc(8'd3);
    readPc(8'd4);
    checkOutput("hold_pre_reset", 16'(holdA), 16'h0);
    RESET = 1'b0;
    #1;
    checkOutput("async_rst_hold", 16'(holdA), 16'h1);
    checkOutput("async_rst_cnt", 16'(cntOutA), 16'h0);
    checkOutput("async_rst_instr", 16'(instrA), 16'h00);
    run_sw = 1'b0;
    tick(1);
    RESET = 1'b1;
    cntA = 0;
    cntB = 0;
    sumA = 8'h00;
    tick(3);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    applyStimulus(8'hF0);
    applyStimulus(8'h20);
    checkOutput("checksum", 16'(sumOutA), 16'(sumA));
    checkOutput("checksum_val", 16'(sumOutA), 16'h10);
    run_sw = 1'b1;
    tick(3);
    run_sw = 1'b0;
    tick(3);
    checkOutput("checksum_clr", 16'(sumOutA), 16'h00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
